// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, opcodes, ALU codes and control bundle for multi_ctrl_fsm.
// ILLEGAL_TRAP_EN adds the TRAP state.
package ctrl_pkg;

    localparam int OP_W       = 6;
    localparam int ALU_CTRL_W = 3;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;

    localparam logic [OP_W-1:0] F_ADD = 6'b100000;
    localparam logic [OP_W-1:0] F_SUB = 6'b100010;
    localparam logic [OP_W-1:0] F_AND = 6'b100100;
    localparam logic [OP_W-1:0] F_OR  = 6'b100101;
    localparam logic [OP_W-1:0] F_SLT = 6'b101010;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

    // AOP_NONE marks states where the ALU is idle; it decodes to 000.
    localparam logic [1:0] AOP_ADD  = 2'b00;
    localparam logic [1:0] AOP_SUB  = 2'b01;
    localparam logic [1:0] AOP_FN   = 2'b10;
    localparam logic [1:0] AOP_NONE = 2'b11;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPE_EX,
        RTYPE_WB,
        BEQ_EX,
        ADDI_EX,
        ADDI_WB,
        JMP_EX
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_e;

    typedef struct packed {
        logic       mem_write;
        logic       i_or_d;
        logic       ireg_enab;
        logic       pc_write;
        logic       pc_src;
        logic       alu_srcA;
        logic [1:0] alu_srcB;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       jmp;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(state_e s);
        ctrl_t c;
        c        = '0;
        c.alu_op = AOP_NONE;
        unique case (s)
            FETCH: begin
                c.ireg_enab = 1'b1;
                c.alu_srcB  = SRCB_4;
                c.alu_op    = AOP_ADD;
                c.pc_write  = 1'b1;
            end
            DECODE: begin
                c.alu_srcB = SRCB_IMM2;
                c.alu_op   = AOP_ADD;
            end
            MEMADR, ADDI_EX: begin
                c.alu_srcA = 1'b1;
                c.alu_srcB = SRCB_IMM;
                c.alu_op   = AOP_ADD;
            end
            MEMRD: c.i_or_d = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            RTYPE_EX: begin
                c.alu_srcA = 1'b1;
                c.alu_srcB = SRCB_RT;
                c.alu_op   = AOP_FN;
            end
            RTYPE_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BEQ_EX: begin
                c.alu_srcA = 1'b1;
                c.alu_srcB = SRCB_RT;
                c.alu_op   = AOP_SUB;
                c.pc_src   = 1'b1;
                c.branch   = 1'b1;
            end
            ADDI_WB: c.reg_write = 1'b1;
            JMP_EX: begin
                c.jmp      = 1'b1;
                c.pc_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_ctrl_fsm_if.sv
// multi_ctrl_fsm_if: clock/reset bundle for the control unit.
// rst is synchronous, active-low.
interface multi_ctrl_fsm_if;
    logic clk;
    logic rst;

    modport central (input clk, input rst);
    modport master  (output clk, output rst);
    modport slave   (input clk, input rst);
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps (alu_op, funct) to the 3-bit ALU control code.
// alu_op 00 add, 01 sub, 10 funct, 11 idle (000).
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0]            alu_op,
    input  logic [OP_W-1:0]       funct,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_sig
);

    always_comb begin
        alu_ctrl_sig = ALU_AND;
        unique case (alu_op)
            AOP_ADD: alu_ctrl_sig = ALU_ADD;
            AOP_SUB: alu_ctrl_sig = ALU_SUB;
            AOP_FN: begin
                unique case (1'b1)
                    funct == F_SUB: alu_ctrl_sig = ALU_SUB;
                    funct == F_AND: alu_ctrl_sig = ALU_AND;
                    funct == F_OR:  alu_ctrl_sig = ALU_OR;
                    funct == F_SLT: alu_ctrl_sig = ALU_SLT;
                    default:        alu_ctrl_sig = ALU_ADD;
                endcase
            end
            default: alu_ctrl_sig = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multi_ctrl_fsm.sv
// multi_ctrl_fsm: Moore control FSM for the multicycle MIPS datapath.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes with a sticky illegal flag.
module multi_ctrl_fsm
    import ctrl_pkg::*;
(
    multi_ctrl_fsm_if.central     ctrl_bus,
    input  logic [31:0]           inst,
    input  logic                  zero,
    output logic                  mem_write,
    output logic                  i_or_d,
    output logic                  ireg_enab,
    output logic                  pc_enab,
    output logic                  pc_src,
    output logic                  alu_srcA,
    output logic [1:0]            alu_srcB,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_sig,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  jmp,
    output logic                  illegal
);

    logic [OP_W-1:0]       op;
    logic [OP_W-1:0]       funct;
    state_e                state;
    state_e                nxt;
    ctrl_t                 c;
    ctrl_t                 nc;
    logic [ALU_CTRL_W-1:0] alu_q;
    logic [ALU_CTRL_W-1:0] alu_d;
    logic                  unused_bits;

    assign op          = inst[31:26];
    assign funct       = inst[5:0];
    assign unused_bits = ^{inst[25:6], c.alu_op};

    always_comb begin
        nxt = FETCH;
        unique case (state)
            FETCH: nxt = DECODE;
            DECODE: begin
                unique case (1'b1)
                    (op == OP_LW) || (op == OP_SW): nxt = MEMADR;
                    op == OP_R:    nxt = RTYPE_EX;
                    op == OP_BEQ:  nxt = BEQ_EX;
                    op == OP_ADDI: nxt = ADDI_EX;
                    op == OP_J:    nxt = JMP_EX;
`ifdef ILLEGAL_TRAP_EN
                    default:       nxt = TRAP;
`else
                    default:       nxt = FETCH;
`endif
                endcase
            end
            MEMADR:   nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    nxt = MEMWB;
            RTYPE_EX: nxt = RTYPE_WB;
            ADDI_EX:  nxt = ADDI_WB;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     nxt = TRAP;
`endif
            default:  nxt = FETCH;
        endcase
        nc = ctrl_of(nxt);
    end

    // Decode for the state being entered so the ALU code is registered too.
    alu_decoder u_alu_dec (
        .alu_op       (nc.alu_op),
        .funct        (funct),
        .alu_ctrl_sig (alu_d)
    );

`ifdef ILLEGAL_TRAP_EN
    logic ill_q;

    always_ff @(posedge ctrl_bus.clk) begin
        if (!ctrl_bus.rst) begin
            state <= FETCH;
            c     <= ctrl_of(FETCH);
            alu_q <= ALU_ADD;
            ill_q <= 1'b0;
        end else begin
            state <= nxt;
            c     <= nc;
            alu_q <= alu_d;
            ill_q <= ill_q | (nxt == TRAP);
        end
    end

    assign illegal = ill_q;
`else
    always_ff @(posedge ctrl_bus.clk) begin
        if (!ctrl_bus.rst) begin
            state <= FETCH;
            c     <= ctrl_of(FETCH);
            alu_q <= ALU_ADD;
        end else begin
            state <= nxt;
            c     <= nc;
            alu_q <= alu_d;
        end
    end

    assign illegal = 1'b0;
`endif

    assign mem_write    = c.mem_write;
    assign i_or_d       = c.i_or_d;
    assign ireg_enab    = c.ireg_enab;
    assign pc_enab      = c.pc_write | (c.branch & zero);
    assign pc_src       = c.pc_src;
    assign alu_srcA     = c.alu_srcA;
    assign alu_srcB     = c.alu_srcB;
    assign alu_ctrl_sig = alu_q;
    assign reg_dst      = c.reg_dst;
    assign mem_to_reg   = c.mem_to_reg;
    assign reg_write    = c.reg_write;
    assign jmp          = c.jmp;

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// tb_multi_ctrl_fsm: random instruction stream checked against a per-instruction
// expected-cycle model, plus directed literal checks.
module tb_multi_ctrl_fsm;

    multi_ctrl_fsm_if bus ();

    logic [31:0] inst;
    logic        zero;
    logic        mem_write, i_or_d, ireg_enab, pc_enab, pc_src, alu_srcA;
    logic [1:0]  alu_srcB;
    logic [2:0]  alu_ctrl_sig;
    logic        reg_dst, mem_to_reg, reg_write, jmp, illegal;

    multi_ctrl_fsm dut (
        .ctrl_bus     (bus),
        .inst         (inst),
        .zero         (zero),
        .mem_write    (mem_write),
        .i_or_d       (i_or_d),
        .ireg_enab    (ireg_enab),
        .pc_enab      (pc_enab),
        .pc_src       (pc_src),
        .alu_srcA     (alu_srcA),
        .alu_srcB     (alu_srcB),
        .alu_ctrl_sig (alu_ctrl_sig),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .jmp          (jmp),
        .illegal      (illegal)
    );

    initial bus.clk = 1'b0;
    always #5 bus.clk = ~bus.clk;

    int vecs = 0;
    int errs = 0;

    logic [15:0] act;
    assign act = {mem_write, i_or_d, ireg_enab, pc_enab, pc_src, alu_srcA,
                  alu_srcB, alu_ctrl_sig, reg_dst, mem_to_reg, reg_write,
                  jmp, illegal};

    localparam logic [15:0] FETCH_V = 16'h3140;

    task automatic chk(input string nm, input logic [15:0] a,
                       input logic [15:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    function automatic logic [15:0] mk(
        bit mw, bit iod, bit ire, bit pce, bit pcs, bit sa,
        bit [1:0] sb, bit [2:0] ac, bit rd, bit mr, bit rw, bit j, bit ill);
        return {mw, iod, ire, pce, pcs, sa, sb, ac, rd, mr, rw, j, ill};
    endfunction

    function automatic bit [2:0] fn_code(bit [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected per-cycle outputs of one instruction; eb marks zero-dependent pc_enab.
    logic [15:0] eq[$];
    bit          eb[$];

    task automatic plan(input logic [31:0] ins);
        eq.delete();
        eb.delete();
        eq.push_back(FETCH_V); eb.push_back(0);
        eq.push_back(mk(0,0,0,0,0,0,2'b11,3'b010,0,0,0,0,0)); eb.push_back(0);
        case (ins[31:26])
            6'b100011: begin
                eq.push_back(mk(0,0,0,0,0,1,2'b10,3'b010,0,0,0,0,0)); eb.push_back(0);
                eq.push_back(mk(0,1,0,0,0,0,2'b00,3'b000,0,0,0,0,0)); eb.push_back(0);
                eq.push_back(mk(0,0,0,0,0,0,2'b00,3'b000,0,1,1,0,0)); eb.push_back(0);
            end
            6'b101011: begin
                eq.push_back(mk(0,0,0,0,0,1,2'b10,3'b010,0,0,0,0,0)); eb.push_back(0);
                eq.push_back(mk(1,1,0,0,0,0,2'b00,3'b000,0,0,0,0,0)); eb.push_back(0);
            end
            6'b000000: begin
                eq.push_back(mk(0,0,0,0,0,1,2'b00,fn_code(ins[5:0]),0,0,0,0,0));
                eb.push_back(0);
                eq.push_back(mk(0,0,0,0,0,0,2'b00,3'b000,1,0,1,0,0)); eb.push_back(0);
            end
            6'b000100: begin
                eq.push_back(mk(0,0,0,0,1,1,2'b00,3'b110,0,0,0,0,0)); eb.push_back(1);
            end
            6'b001000: begin
                eq.push_back(mk(0,0,0,0,0,1,2'b10,3'b010,0,0,0,0,0)); eb.push_back(0);
                eq.push_back(mk(0,0,0,0,0,0,2'b00,3'b000,0,0,1,0,0)); eb.push_back(0);
            end
            6'b000010: begin
                eq.push_back(mk(0,0,0,1,0,0,2'b00,3'b000,0,0,0,1,0)); eb.push_back(0);
            end
            default: ;
        endcase
    endtask

    task automatic drive_zero(input int zmode);
        if (zmode == 1)      zero = 1'b1;
        else if (zmode == 2) zero = 1'b0;
        else                 zero = 1'($urandom_range(0, 1));
    endtask

    // Entered and left at negedge+1 with the DUT in FETCH.
    task automatic run(input logic [31:0] ins, input string nm,
                       input int zmode, input int limit);
        int n;
        plan(ins);
        n = (limit > 0 && limit < eq.size()) ? limit : eq.size();
        inst = ins;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge bus.clk);
                drive_zero(zmode);
                #1;
            end
            chk($sformatf("%s c%0d", nm, i), act,
                eq[i] | ((eb[i] && zero) ? 16'h1000 : 16'h0000));
        end
        if (n < eq.size()) bus.rst = 1'b0;
        @(negedge bus.clk);
        drive_zero(0);
        #1;
        if (n < eq.size()) begin
            chk($sformatf("%s rst_fetch", nm), act, FETCH_V);
            bus.rst = 1'b1;
        end
    endtask

    function automatic bit known_op(bit [5:0] o);
        return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
    endfunction

    logic [31:0] rnd;
    logic [5:0]  rop;
    int          kind;
    logic [5:0]  fl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        bus.rst = 1'b0;
        inst    = 32'h0;
        zero    = 1'b0;
        repeat (2) @(negedge bus.clk);
        #1;
        chk("reset", act, FETCH_V);
        bus.rst = 1'b1;

        run(32'h8C220004, "lw", 0, 0);
        run(32'h10220003, "beq_z1", 1, 0);
        run(32'h10220003, "beq_z0", 2, 0);

        inst = 32'h10220003;
        @(negedge bus.clk); #1;
        @(negedge bus.clk); zero = 1'b1; #1;
        chk("beq_lit_taken", {11'h0, pc_enab, pc_src, alu_ctrl_sig}, 16'h001E);
        zero = 1'b0; #1;
        chk("beq_lit_nottaken", {15'h0, pc_enab}, 16'h0000);
        @(negedge bus.clk); #1;
        chk("beq_lit_back", {15'h0, ireg_enab}, 16'h0001);

        inst = 32'h0022182A;
        @(negedge bus.clk); #1;
        @(negedge bus.clk); #1;
        chk("slt_lit_ex", {10'h0, alu_ctrl_sig, alu_srcA, alu_srcB}, 16'h003C);
        @(negedge bus.clk); #1;
        chk("slt_lit_wb", {14'h0, reg_dst, reg_write}, 16'h0003);
        @(negedge bus.clk); #1;

        run(32'h0022182A, "slt", 0, 0);
        run(32'hAC220004, "sw", 0, 0);
        run(32'hAC220004, "sw_rst", 0, 3);
        run(32'h20220005, "addi", 0, 0);
        run(32'h08000010, "j", 0, 0);
`ifndef ILLEGAL_TRAP_EN
        run(32'hFC000000, "ill", 0, 0);
        chk("ill_lit_fetch", {15'h0, ireg_enab}, 16'h0001);
`endif

        for (int k = 0; k < 400; k++) begin
            rnd = $urandom;
`ifdef ILLEGAL_TRAP_EN
            kind = $urandom_range(0, 5);
`else
            kind = $urandom_range(0, 6);
`endif
            case (kind)
                0: rop = 6'b000000;
                1: rop = 6'b100011;
                2: rop = 6'b101011;
                3: rop = 6'b000100;
                4: rop = 6'b001000;
                5: rop = 6'b000010;
                default: begin
                    rop = 6'($urandom);
                    while (known_op(rop)) rop = 6'($urandom);
                end
            endcase
            rnd[31:26] = rop;
            if (kind == 0 && $urandom_range(0, 3) != 0)
                rnd[5:0] = fl[$urandom_range(0, 4)];
            run(rnd, $sformatf("rnd%0d", k), 0, 0);
            if ($urandom_range(0, 40) == 0)
                run(rnd, $sformatf("rnd%0d_rst", k), 0, $urandom_range(1, 2));
        end

`ifdef ILLEGAL_TRAP_EN
        inst = 32'hFC000000;
        @(negedge bus.clk); #1;
        for (int k = 0; k < 10; k++) begin
            @(negedge bus.clk);
            zero = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("trap c%0d", k), act, 16'h0001);
        end
        bus.rst = 1'b0;
        @(negedge bus.clk); #1;
        chk("trap_rst", act, FETCH_V);
        bus.rst = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/multi_ctrl_fsm.md
Name: multi_ctrl_fsm

Overview:
Control unit for the multicycle MIPS core; drives every control input of the multicycle datapath.
- Moore FSM sequences fetch/decode/execute/memory/writeback per instruction using inst[31:26] (op) and inst[5:0] (funct).
- Combines branch with the ALU zero flag to form pc_enab.
- Sits beside the datapath inside cpu; consumes inst and zero, produces all select/enable signals plus the memory write strobe.

Parameters:
OP_W, 6, opcode/funct field width
ALU_CTRL_W, 3, ALU control code width

Ports:
ctrl_bus  input (modport central)  intf  carries clk and rst; one clock, rst is synchronous, active-low
inst  input  32  instruction register contents (op = [31:26], funct = [5:0])
zero  input  1  ALU zero flag (combinational, current cycle)
mem_write  output  1  memory write strobe (to mem_bus)
i_or_d  output  1  address select: 0 = pc, 1 = alu_out
ireg_enab  output  1  instruction register load
pc_enab  output  1  PC load
pc_src  output  1  0 = alu_res, 1 = alu_out
alu_srcA  output  1  0 = pc, 1 = rs
alu_srcB  output  2  00 = rt, 01 = 4, 10 = imm, 11 = imm<<2
alu_ctrl_sig  output  3  ALU operation
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = alu_out, 1 = read_data
reg_write  output  1  register file write
jmp  output  1  jump cycle indicator
illegal  output  1  sticky illegal-opcode flag (feature only; tied 0 otherwise)

Behaviour:
- State register updates on the clk rising edge. rst low at an edge forces FETCH, including mid-instruction.
- Outputs are decoded from state only, except pc_enab = pc_write | (branch & zero).
- Every output is 0 unless listed below. In reset/FETCH the listed values apply; with rst held low, FETCH values are shown.
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Per-state outputs:
  - FETCH: i_or_d 0, ireg_enab 1, alu_srcA 0, alu_srcB 01, add, pc_src 0, pc_write 1. Next: DECODE.
  - DECODE: alu_srcA 0, alu_srcB 11, add (branch target into alu_out). Next by op: lw/sw -> MEMADR; R -> RTYPE_EX; beq -> BEQ_EX; addi -> ADDI_EX; j -> JMP_EX; other -> FETCH (or TRAP with the feature).
  - MEMADR: alu_srcA 1, alu_srcB 10, add. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD: i_or_d 1. Next: MEMWB.
  - MEMWB: reg_dst 0, mem_to_reg 1, reg_write 1. Next: FETCH.
  - MEMWR: i_or_d 1, mem_write 1. Next: FETCH.
  - RTYPE_EX: alu_srcA 1, alu_srcB 00, alu_ctrl from funct. Next: RTYPE_WB.
  - RTYPE_WB: reg_dst 1, mem_to_reg 0, reg_write 1. Next: FETCH.
  - BEQ_EX: alu_srcA 1, alu_srcB 00, sub, pc_src 1, branch 1. Next: FETCH.
  - ADDI_EX: alu_srcA 1, alu_srcB 10, add. Next: ADDI_WB.
  - ADDI_WB: reg_dst 0, mem_to_reg 0, reg_write 1. Next: FETCH.
  - JMP_EX: jmp 1, pc_write 1. Next: FETCH.
- Funct decode (RTYPE_EX only): 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct -> add.
- Cycles per instruction: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- ireg_enab is high only in FETCH, so inst is stable from DECODE onward.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an unknown op in DECODE enters TRAP. TRAP drives all outputs 0, including pc_enab; illegal = 1. TRAP is exited only by reset.
- Undefined: an unknown op returns to FETCH as a 2-cycle no-op; illegal is tied 0 and TRAP does not exist.

Decomposition:
- Package ctrl_pkg: state_e enum, opcode and funct localparams, ALU code localparams, alu_srcB select encodings.
- Sub-module alu_decoder: combinational, (alu_op[1:0], funct) -> alu_ctrl_sig; alu_op 00 = add, 01 = sub, 10 = funct.

Test Plan:
- Reset: rst low 2 cycles, then high -> state FETCH; ireg_enab=1, pc_enab=1, alu_srcB=01, alu_ctrl_sig=010.
- lw (inst=0x8C220004): states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; reg_write=1 with mem_to_reg=1 only in cycle 5; mem_write never 1.
- beq (inst=0x10220003): zero=1 in BEQ_EX -> pc_enab=1, pc_src=1, alu_ctrl_sig=110. With zero=0 -> pc_enab=0. Back in FETCH next cycle in both cases.
- R-type slt (funct 101010): RTYPE_EX gives alu_ctrl_sig=111, alu_srcA=1, alu_srcB=00; RTYPE_WB gives reg_dst=1, reg_write=1.
- Reset mid-sw: rst low during MEMADR -> FETCH at the next edge; mem_write never asserted.
- Illegal op 111111:
  - With ILLEGAL_TRAP_EN: illegal=1 and pc_enab=0 held for 10 cycles.
  - Without: FETCH reached 2 cycles after the first FETCH.
